// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Optional single-cycle multiplier build: MULDIV_FAST_MUL_EN (see ex_muldiv_unit.sv).
package riscv_muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } md_state_e;

    // rs1 is treated as signed by every op except the fully unsigned ones.
    function automatic logic rs1_is_signed(input logic [2:0] funct3);
        return !(funct3 == MD_MULHU || funct3 == MD_DIVU || funct3 == MD_REMU);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] funct3);
        return (funct3 == MD_MUL || funct3 == MD_MULH || funct3 == MD_DIV || funct3 == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-to-EX/MEM handshake bundle of the multiply/divide unit.
// master = pipeline side, slave = the unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_in;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] rs1_data_in;
    logic [XLEN-1:0] rs2_data_in;
    logic [4:0]      rd_in;
    logic            flush;
    logic            stall_out;
    logic            result_valid;
    logic [XLEN-1:0] result_out;
    logic [4:0]      rd_out;

    modport master (
        output valid_in, funct3_in, rs1_data_in, rs2_data_in, rd_in, flush,
        input  stall_out, result_valid, result_out, rd_out
    );

    modport slave (
        input  valid_in, funct3_in, rs1_data_in, rs2_data_in, rd_in, flush,
        output stall_out, result_valid, result_out, rd_out
    );
endinterface

// File: rtl/ex_muldiv_unit_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// shift-subtract divide over a {hi, lo} accumulator.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_rem;
    logic [XLEN+1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem_next;

    // Multiply: lo holds the remaining multiplier bits, hi the partial product.
    assign mul_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);

    // Divide: lo shifts dividend bits into hi and collects quotient bits at the bottom.
    assign div_rem      = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
    assign div_diff     = {1'b0, div_rem} - {2'b00, operand};
    assign div_ge       = ~div_diff[XLEN+1];
    assign div_rem_next = div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0];

    always_comb begin
        acc_out = '0;
        if (is_div) begin
            acc_out = {div_rem_next, acc_in[XLEN-2:0], div_ge};
        end else begin
            acc_out = {mul_sum, acc_in[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage (32 iteration cycles).
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle multiplier.
module ex_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ITER_CNT_W = 5
) (
    input logic              clk,
    input logic              reset_n,
    ex_muldiv_unit_if.slave  bus
);
    md_state_e             state_q, state_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [4:0]            rd_q, rd_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]       opb_q, opb_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [4:0]            rd_out_q, rd_out_d;
    logic                  stall;

    logic                  sign_a, sign_b;
    logic [XLEN-1:0]       mag_a, mag_b;
    logic                  accept;
    logic                  in_is_div;
    logic                  div_by_zero;

    logic [2*XLEN-1:0]     step_acc;
    logic [2*XLEN-1:0]     prod_fixed;
    logic [XLEN-1:0]       quot_fixed, rem_fixed;
    logic [XLEN-1:0]       calc_result;

    assign sign_a      = rs1_is_signed(bus.funct3_in) & bus.rs1_data_in[XLEN-1];
    assign sign_b      = rs2_is_signed(bus.funct3_in) & bus.rs2_data_in[XLEN-1];
    assign mag_a       = sign_a ? (~bus.rs1_data_in + 1'b1) : bus.rs1_data_in;
    assign mag_b       = sign_b ? (~bus.rs2_data_in + 1'b1) : bus.rs2_data_in;
    assign accept      = bus.valid_in & ~bus.flush;
    assign in_is_div   = bus.funct3_in[2];
    assign div_by_zero = in_is_div & (bus.rs2_data_in == '0);

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div  (funct3_q[2]),
        .acc_in  (acc_q),
        .operand (opb_q),
        .acc_out (step_acc)
    );

    // Sign fix-up of the final iteration's output, applied on DONE entry.
    assign prod_fixed = neg_res_q ? (~step_acc + 1'b1) : step_acc;
    assign quot_fixed = neg_res_q ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0];
    assign rem_fixed  = neg_rem_q ? (~step_acc[2*XLEN-1:XLEN] + 1'b1)
                                  : step_acc[2*XLEN-1:XLEN];

    always_comb begin
        calc_result = '0;
        if (funct3_q[2]) begin
            calc_result = funct3_q[1] ? rem_fixed : quot_fixed;
        end else begin
            calc_result = (funct3_q == MD_MUL) ? prod_fixed[XLEN-1:0]
                                               : prod_fixed[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]          fast_result;

    assign fast_prod = $signed({sign_a & 1'b1 & bus.rs1_data_in[XLEN-1], bus.rs1_data_in})
                     * $signed({sign_b & 1'b1 & bus.rs2_data_in[XLEN-1], bus.rs2_data_in});
    assign fast_result = (bus.funct3_in == MD_MUL) ? fast_prod[XLEN-1:0]
                                                   : fast_prod[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        stall     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    funct3_d  = bus.funct3_in;
                    rd_d      = bus.rd_in;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_d     = {{XLEN{1'b0}}, mag_a};
                    opb_d     = mag_b;
                    cnt_d     = '0;
                    if (div_by_zero) begin
                        // Remainder by zero returns rs1 as-is, without sign fix-up.
                        state_d  = DONE;
                        result_d = bus.funct3_in[1] ? bus.rs1_data_in : DIV_ZERO_Q;
                        rd_out_d = bus.rd_in;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!in_is_div) begin
                        state_d  = DONE;
                        result_d = fast_result;
                        rd_out_d = bus.rd_in;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall = 1'b1;
                acc_d = step_acc;
                cnt_d = cnt_q + ITER_CNT_W'(1);
                if (cnt_q == ITER_CNT_W'(XLEN - 1)) begin
                    state_d  = DONE;
                    result_d = calc_result;
                    rd_out_d = rd_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d  = IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign bus.stall_out    = stall;
    assign bus.result_valid = (state_q == DONE);
    assign bus.result_out   = result_q;
    assign bus.rd_out       = rd_out_q;
endmodule
